mboot_key_ctrl: RTL
===================

// Module: mboot_key_ctrl
// PURPOSE
//   Requester side of the multiboot interface: turns the raw user key into the
//   active-low reboot request and dynamic boot address consumed by EG_LOGIC_MBOOT.
//   Short press steps the selected image (shown one-hot on RGB_LED); long press fires the reboot.
//   Sits between the board key pin and the mboot primitive, replacing a direct key-to-rebootn wire.
// PARAMETERS
//   DEBOUNCE_CYC  240_000     consecutive stable samples before key level is accepted (10 ms @ 24 MHz)
//   LONG_CYC      48_000_000  debounced hold length that triggers reboot (2 s @ 24 MHz)
//   PULSE_CYC     16          cycles REBOOT_N is held low
//   NUM_IMG       3           selectable images, 1..3 (one LED per image)
//   BASE_ADDR     8'h00       boot address of image 0
//   ADDR_STEP     8'h0a       address increment per image index
// PORTS
//   CLK_IN     in   1  system clock
//   RST        in   1  synchronous reset, active-high
//   KEY_N      in   1  raw key, asynchronous, low = pressed
//   REBOOT_N   out  1  reboot request to mboot primitive, active-low pulse
//   BOOT_ADDR  out  8  dynamic boot address, stable from fire until reset
//   RGB_LED    out  3  one-hot selected image; 3'b111 while reboot is pending
//   BUSY       out  1  high from long-press fire onwards
// BEHAVIOUR
//   Reset (RST=1 at CLK_IN edge): REBOOT_N=1, BOOT_ADDR=BASE_ADDR, RGB_LED=3'b001, BUSY=0,
//     sel=0, sync flops=1, debounced key=released, counters=0, state=IDLE. Reset wins over all.
//   Input: 2-flop synchronizer on KEY_N. Debounce: counter increments while synced
//     level != debounced level, clears when equal; on reaching DEBOUNCE_CYC the debounced
//     level toggles next edge and counter clears. Glitches shorter than DEBOUNCE_CYC ignored.
//   FSM (advances on debounced level only):
//     IDLE  : press edge -> HOLD, hold counter=0.
//     HOLD  : hold counter +1 per cycle, saturating. Release before LONG_CYC -> IDLE and
//             sel = (sel==NUM_IMG-1) ? 0 : sel+1. Counter reaching LONG_CYC -> FIRE
//             (no release needed); BOOT_ADDR <= BASE_ADDR + sel*ADDR_STEP (8-bit, wraps mod 256).
//     FIRE  : REBOOT_N=0 for exactly PULSE_CYC cycles, BUSY=1, RGB_LED=3'b111 -> DONE.
//     DONE  : REBOOT_N=1, BUSY=1, RGB_LED=3'b111; all key activity ignored; exit only on RST.
//   RGB_LED outside FIRE/DONE = 3'b001 << sel; bits >= NUM_IMG stay 0.
//   BOOT_ADDR changes only at the HOLD->FIRE edge; REBOOT_N first low one cycle after it.
//   Press at release-edge coinciding with LONG_CYC reached: long press wins (FIRE).
//   Reset mid-FIRE: REBOOT_N returns to 1 same edge, sel back to 0.
//   Key held through reset: debounced level restarts as released; a new press edge is
//     seen after DEBOUNCE_CYC, so a held key re-enters HOLD from zero.
//   Counter widths sized by $clog2 of the respective parameter + 1; no overflow.
// TESTING  (bench params: DEBOUNCE_CYC=4, LONG_CYC=20, PULSE_CYC=3, NUM_IMG=3, ADDR_STEP=8'h0a)
//   Reset then idle 50 cycles -> REBOOT_N=1, RGB_LED=3'b001, BOOT_ADDR=8'h00, BUSY=0.
//   3-cycle low glitch on KEY_N -> no state change, RGB_LED stays 3'b001.
//   Three short presses (10 cycles low, 10 high) -> RGB_LED 010, 100, then wraps to 001.
//   One short press then hold 40 cycles -> BOOT_ADDR=8'h0a, REBOOT_N low exactly 3 cycles,
//     RGB_LED=3'b111, BUSY=1; further presses ignored.
//   Two short presses then long hold -> BOOT_ADDR=8'h14; RST pulse in FIRE -> REBOOT_N=1,
//     RGB_LED=3'b001, BOOT_ADDR=8'h00 on the following cycle.
//   Key held low across RST deassert -> HOLD re-entered, FIRE 2+4+20 cycles after reset release.

Source files
------------

// File: rtl/mboot_key_ctrl.sv
// mboot_key_ctrl
//   Requester side of the multiboot interface. Turns the raw user key into the
//   active-low reboot request and the dynamic boot address for EG_LOGIC_MBOOT.
//   A short press steps the selected image (shown one-hot on RGB_LED). A long
//   press latches the boot address of the selected image and fires the reboot.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | key released, waiting for a debounced press
//   HOLD  | key pressed, hold counter running toward LONG_CYC
//   FIRE  | boot address latched, REBOOT_N pulse in progress
//   DONE  | pulse finished, key ignored until reset
//
// Ports
//   CLK_IN    in   1  system clock
//   RST       in   1  synchronous reset, active-high
//   KEY_N     in   1  raw key, asynchronous, low = pressed
//   REBOOT_N  out  1  reboot request, active-low pulse of PULSE_CYC cycles
//   BOOT_ADDR out  8  boot address, updated only on HOLD->FIRE
//   RGB_LED   out  3  one-hot selected image, 3'b111 once reboot is pending
//   BUSY      out  1  high from long-press fire onwards
module mboot_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 240_000,
    parameter int unsigned LONG_CYC     = 48_000_000,
    parameter int unsigned PULSE_CYC    = 16,
    parameter int unsigned NUM_IMG      = 3,
    parameter logic [7:0]  BASE_ADDR    = 8'h00,
    parameter logic [7:0]  ADDR_STEP    = 8'h0a
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       KEY_N,
    output logic       REBOOT_N,
    output logic [7:0] BOOT_ADDR,
    output logic [2:0] RGB_LED,
    output logic       BUSY
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int HOLD_W  = $clog2(LONG_CYC) + 1;
    localparam int PULSE_W = $clog2(PULSE_CYC) + 1;
    localparam int SEL_W   = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_CYC);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYC - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_IMG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_FIRE = 2'd2,
        S_DONE = 2'd3
    } state_e;

    logic             key_s1_q, key_s2_q;
    logic             deb_q;          // debounced key, 1 = released
    logic [DEB_W-1:0] deb_cnt_q;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [7:0]         addr_q, addr_d;
    logic               reboot_n_q, reboot_n_d;
    logic [7:0]         addr_calc;

    // Synchronizer and debounce. The debounced level flips on the
    // DEBOUNCE_CYC-th consecutive synced sample that disagrees with it.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            key_s1_q <= KEY_N;
            key_s2_q <= key_s1_q;
            if (key_s2_q != deb_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    deb_q     <= key_s2_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + 1'b1;
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

    assign addr_calc = BASE_ADDR + ADDR_STEP * 8'(sel_q);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        reboot_n_d  = (state_q != S_FIRE);
        case (state_q)
            S_IDLE: begin
                if (!deb_q) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // Long press is checked first so it wins over a coincident release.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = S_FIRE;
                    pulse_cnt_d = '0;
                    addr_d      = addr_calc;
                end else if (deb_q) begin
                    state_d = S_IDLE;
                    sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end
            end
            S_FIRE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // REBOOT_N is registered from the state, so it goes low one cycle after
    // entering FIRE and stays low for exactly PULSE_CYC cycles.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            sel_q       <= '0;
            addr_q      <= BASE_ADDR;
            reboot_n_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            reboot_n_q  <= reboot_n_d;
        end
    end

    assign BUSY      = (state_q == S_FIRE) || (state_q == S_DONE);
    assign REBOOT_N  = reboot_n_q;
    assign BOOT_ADDR = addr_q;
    assign RGB_LED   = BUSY ? 3'b111 : (3'b001 << sel_q);

endmodule
